// File: rtl/rr_mux4_collector.sv
// ---------------------------------------------------------------------------
// rr_mux4_collector
//
// Purpose:
//   Gathering end of a 1-to-4 demux fabric. Four independent source channels,
//   each with a valid/ready handshake, merge into one registered output
//   stream. Channel selection is fair round-robin. The index of the channel
//   that supplied the held word is presented on out_sel, using the same 2-bit
//   selector encoding the demux side consumes. One output register gives
//   1-cycle latency at a sustained 1 word/cycle.
//
// Handshake semantics (both sides):
//   A word moves across an interface on a rising clk edge where valid and
//   ready are both high. A source must hold valid and data stable until the
//   word is accepted; this block does not check that. in_ready is
//   combinational, and at most one bit of it is high. out_valid never
//   depends on out_ready.
//
// Ports:
//   clk        in   1          system clock, rising edge
//   rst        in   1          synchronous reset, active-high, highest priority
//   in_valid   in   4          bit i: channel i presents a word
//   in_data    in   4*DATA_W   channel i word at [i*DATA_W +: DATA_W]
//   in_ready   out  4          bit i: channel i word accepted this cycle
//   out_valid  out  1          output register holds a word (FULL state)
//   out_data   out  DATA_W     held word
//   out_sel    out  2          source channel index of the held word
//   out_ready  in   1          downstream accepts the held word this cycle
//   out_parity out  1          only when RR_MUX_PARITY_EN is defined:
//                              XOR reduction of the held word
//
// Configuration macro:
//   RR_MUX_PARITY_EN  adds the registered out_parity output. When it is
//                     undefined the port and its logic are absent and all
//                     other behaviour is identical.
// ---------------------------------------------------------------------------
module rr_mux4_collector #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            in_valid,
    input  logic [4*DATA_W-1:0]   in_data,
    output logic [3:0]            in_ready,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    output logic [1:0]            out_sel,
`ifdef RR_MUX_PARITY_EN
    output logic                  out_parity,
`endif
    input  logic                  out_ready
);

    // -----------------------------------------------------------------------
    // Output register state. out_valid is a direct decode of this state, so
    // the FSM is externally visible without an extra port.
    // -----------------------------------------------------------------------
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [1:0]            ptr_q,   ptr_d;
    logic [DATA_W-1:0]     data_q,  data_d;
    logic [1:0]            sel_q,   sel_d;

    // Arbitration signals
    logic                  load_ok;
    logic                  any_valid;
    logic                  grant_found;
    logic [1:0]            grant_idx;
    logic [1:0]            cand;
    logic                  transfer;
    logic [DATA_W-1:0]     grant_word;

    // The register can take a new word when it is empty or when the word it
    // holds leaves on this same edge (drain and load together, no bubble).
    assign load_ok   = (state_q == ST_EMPTY) || out_ready;
    assign any_valid = |in_valid;

    // -----------------------------------------------------------------------
    // Round-robin search: ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first channel
    // with in_valid set wins. The 2-bit wrap of cand gives the mod-4 order.
    // -----------------------------------------------------------------------
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = 2'd0;
        cand        = ptr_q;
        for (int k = 0; k < 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!grant_found && in_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // A grant becomes a transfer only when the register can load. Reset
    // suppresses acceptance so that no source believes its word was taken
    // while the register is being cleared.
    assign transfer   = !rst && load_ok && any_valid && grant_found;
    assign grant_word = in_data[grant_idx*DATA_W +: DATA_W];

    always_comb begin
        in_ready = 4'b0000;
        if (transfer) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic for the output register and the round-robin pointer.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        sel_d   = sel_q;

        if (transfer) begin
            // New word loads; any held word leaves on the same edge.
            state_d = ST_FULL;
            data_d  = grant_word;
            sel_d   = grant_idx;
            ptr_d   = grant_idx + 2'd1;
        end else if ((state_q == ST_FULL) && out_ready) begin
            // Drain with nothing to replace it. data/sel keep their values.
            state_d = ST_EMPTY;
        end
        // Otherwise: idle when empty, or stalled when full; everything holds.
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            ptr_q   <= 2'd0;
            data_q  <= '0;
            sel_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = data_q;
    assign out_sel   = sel_q;

`ifdef RR_MUX_PARITY_EN
    // Parity travels with the word: it loads only on a transfer and therefore
    // holds together with out_data through stalls and drains.
    logic parity_q, parity_d;

    always_comb begin
        parity_d = parity_q;
        if (transfer) begin
            parity_d = ^grant_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_rr_mux4_collector.sv
// ---------------------------------------------------------------------------
// tb_rr_mux4_collector
//
// Directed bench for rr_mux4_collector. Inputs change 1 ns after each rising
// edge; combinational in_ready is checked 1 ns after that, and registered
// outputs are checked right after the edge that should have updated them.
// ---------------------------------------------------------------------------
module tb_rr_mux4_collector;

  localparam int DATA_W = 8;

  logic                clk;
  logic                rst;
  logic [3:0]          in_valid;
  logic [4*DATA_W-1:0] in_data;
  logic [3:0]          in_ready;
  logic                out_valid;
  logic [DATA_W-1:0]   out_data;
  logic [1:0]          out_sel;
  logic                out_ready;
`ifdef RR_MUX_PARITY_EN
  logic                out_parity;
`endif

  int n_vec;
  int n_err;

  rr_mux4_collector #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
`ifdef RR_MUX_PARITY_EN
    .out_parity(out_parity),
`endif
    .out_ready (out_ready)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] s);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".data"},  32'(out_data),  32'(d));
    chk({tag, ".sel"},   32'(out_sel),   32'(s));
  endtask

  task automatic chk_rdy(input string tag, input logic [3:0] r);
    #1;
    chk({tag, ".ready"}, 32'(in_ready), 32'(r));
  endtask

  task automatic set_data(input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [7:0] d3);
    in_data = {d3, d2, d1, d0};
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    // ---- reset with all channels valid, then idle ----
    rst       = 1'b1;
    in_valid  = 4'b1111;
    set_data(8'h10, 8'h11, 8'h12, 8'h13);
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_out("rst", 1'b0, 8'h00, 2'd0);
      chk("rst.ready", 32'(in_ready), 32'(4'b0000));
    end
    rst      = 1'b0;
    in_valid = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      chk_rdy("idle", 4'b0000);
      tick();
      chk_out("idle", 1'b0, 8'h00, 2'd0);
    end

    // ---- single channel, 1-cycle latency ----
    in_valid = 4'b0100;
    set_data(8'h00, 8'h00, 8'hA5, 8'h00);
    chk_rdy("single", 4'b0100);
    tick();
    chk_out("single", 1'b1, 8'hA5, 2'd2);
`ifdef RR_MUX_PARITY_EN
    chk("single.parity", 32'(out_parity), 32'(1'b0));
`endif
    // drain with no new word: valid drops, data/sel hold
    in_valid = 4'b0000;
    chk_rdy("drain", 4'b0000);
    tick();
    chk_out("drain", 1'b0, 8'hA5, 2'd2);

    // pointer is 3 now; reset it so the fairness run starts at channel 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_out("rst2", 1'b0, 8'h00, 2'd0);

    // ---- round-robin fairness and wrap-around ----
    in_valid = 4'b1111;
    set_data(8'h10, 8'h11, 8'h12, 8'h13);
    for (int k = 0; k < 8; k++) begin
      chk_rdy("rr", 4'(1 << (k % 4)));
      tick();
      chk_out("rr", 1'b1, 8'(8'h10 + (k % 4)), 2'(k % 4));
    end
    // pointer back at 0

    // ---- backpressure ----
    in_valid = 4'b0010;
    set_data(8'h5A, 8'h3C, 8'h00, 8'h00);
    chk_rdy("bp.load", 4'b0010);
    tick();
    chk_out("bp.load", 1'b1, 8'h3C, 2'd1);
    in_valid  = 4'b0001;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_rdy("bp.stall", 4'b0000);
      tick();
      chk_out("bp.stall", 1'b1, 8'h3C, 2'd1);
    end
    out_ready = 1'b1;
    chk_rdy("bp.drain", 4'b0001);
    tick();
    chk_out("bp.drain", 1'b1, 8'h5A, 2'd0);
    // pointer = 1

    // ---- pointer start position ----
    in_valid = 4'b0010;
    set_data(8'h0F, 8'h77, 8'h00, 8'hC3);
    chk_rdy("ptr.ch1", 4'b0010);
    tick();
    chk_out("ptr.ch1", 1'b1, 8'h77, 2'd1);
    // pointer = 2: channel 3 must win over channel 0
    in_valid = 4'b1001;
    chk_rdy("ptr.ch3", 4'b1000);
    tick();
    chk_out("ptr.ch3", 1'b1, 8'hC3, 2'd3);
    in_valid = 4'b0001;
    chk_rdy("ptr.ch0", 4'b0001);
    tick();
    chk_out("ptr.ch0", 1'b1, 8'h0F, 2'd0);

    // ---- reset mid-stream ----
    in_valid = 4'b0000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 4'b1111;
    set_data(8'h10, 8'h11, 8'h12, 8'h13);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_out("mid.pre", 1'b1, 8'(8'h10 + k), 2'(k));
    end
    rst = 1'b1;
    chk_rdy("mid.rst", 4'b0000);
    tick();
    rst = 1'b0;
    chk_out("mid.rst", 1'b0, 8'h00, 2'd0);
    chk_rdy("mid.post", 4'b0001);
    tick();
    chk_out("mid.post", 1'b1, 8'h10, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
